// File: rtl/smj_pkg.sv
// Shared types and constants for the SMJ hand loader slice.
//
// Contents:
//   TILE_W, HAND_N, RES_W, CNT_W  - tile width, tiles per hand, verdict width,
//                                   hand counter width
//   tile_t, hand_t, res_t         - tile code, packed five-tile hand, verdict
//   loader_state_e                - loader FSM states (COLLECT, EVAL, HOLD)
//
// Optional feature macro used by the files importing this package: HAND_SORT_EN.
package smj_pkg;

  localparam int TILE_W = 6;
  localparam int HAND_N = 5;
  localparam int RES_W  = 2;
  localparam int CNT_W  = 3;

  typedef logic [TILE_W-1:0]      tile_t;
  typedef tile_t [HAND_N-1:0]     hand_t;
  typedef logic [RES_W-1:0]       res_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    HOLD    = 2'd2
  } loader_state_e;

endpackage

// File: rtl/smj_sort_insert.sv
// Combinational insertion step for the hand loader.
//
// Given a hand whose slots 0..cnt-1 are already in ascending unsigned order,
// returns the hand with new_tile inserted so slots 0..cnt stay ascending.
// Entries larger than new_tile shift up one slot; slots above cnt pass through.
// Ties are stable: new_tile lands after any existing equal tiles.
//
// Ports:
//   hand      in   hand_t   current hand contents
//   cnt       in   CNT_W    number of valid (sorted) entries in hand
//   new_tile  in   tile_t   tile being inserted
//   hand_out  out  hand_t   hand after insertion
//
// Used by smj_hand_loader only when HAND_SORT_EN is defined.
import smj_pkg::*;

module smj_sort_insert (
  input  hand_t             hand,
  input  logic [CNT_W-1:0]  cnt,
  input  tile_t             new_tile,
  output hand_t             hand_out
);

  logic [CNT_W-1:0] pos;

  always_comb begin
    // Valid entries are sorted, so the ones <= new_tile form a prefix; its
    // length is the insertion point. Using <= keeps equal tiles ahead.
    pos = '0;
    for (int i = 0; i < HAND_N; i++) begin
      if ((CNT_W'(i) < cnt) && (hand[i] <= new_tile)) begin
        pos = pos + 1'b1;
      end
    end

    hand_out = hand;
    for (int i = 0; i < HAND_N; i++) begin
      if (CNT_W'(i) < pos) begin
        hand_out[i] = hand[i];
      end else if (CNT_W'(i) == pos) begin
        hand_out[i] = new_tile;
      end else if (CNT_W'(i) <= cnt) begin
        hand_out[i] = hand[(i == 0) ? 0 : i - 1];
      end else begin
        hand_out[i] = hand[i];
      end
    end
  end

endmodule

// File: rtl/smj_hand_loader.sv
// Upstream feeder for the SMJ hand evaluator.
//
// Collects five tiles from a valid/ready stream, presents them as a stable
// hand on hand_n0..hand_n4, registers SMJ's combinational verdict one cycle
// later and offers it downstream on a valid/ready output.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid must be held with stable data until that edge, and ready may be
// any value irrespective of valid.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             abandon the current hand (clears count and out_valid)
//   in_valid/in_tile/in_ready     tile input stream
//   hand_n0..hand_n4  registered hand slots driven into SMJ
//   smj_data          verdict returned combinationally by SMJ
//   out_valid/out_data/out_ready  verdict output stream
//   hand_cnt          tiles currently buffered (0..5)
//   state_dbg         current loader FSM state (loader_state_e encoding)
//
// Build option: HAND_SORT_EN - keep the hand in ascending order by inserting
// each accepted tile at its sorted position; otherwise slots hold tiles in
// arrival order.
import smj_pkg::*;

module smj_hand_loader (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [TILE_W-1:0] in_tile,
  output logic              in_ready,
  output logic [TILE_W-1:0] hand_n0,
  output logic [TILE_W-1:0] hand_n1,
  output logic [TILE_W-1:0] hand_n2,
  output logic [TILE_W-1:0] hand_n3,
  output logic [TILE_W-1:0] hand_n4,
  input  logic [RES_W-1:0]  smj_data,
  output logic              out_valid,
  output logic [RES_W-1:0]  out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  hand_cnt,
  output logic [1:0]        state_dbg
);

  loader_state_e state;
  hand_t         hand;
  hand_t         hand_next;
  logic          accept;

  assign accept = in_valid && in_ready;

`ifdef HAND_SORT_EN
  smj_sort_insert u_sort_insert (
    .hand     (hand),
    .cnt      (hand_cnt),
    .new_tile (in_tile),
    .hand_out (hand_next)
  );
`else
  always_comb begin
    hand_next = hand;
    for (int i = 0; i < HAND_N; i++) begin
      if (hand_cnt == CNT_W'(i)) begin
        hand_next[i] = in_tile;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      hand      <= '0;
      hand_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      // Slots and out_data are left as they are; only the bookkeeping resets.
      state     <= COLLECT;
      hand_cnt  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            hand     <= hand_next;
            hand_cnt <= hand_cnt + 1'b1;
            if (hand_cnt == CNT_W'(HAND_N - 1)) begin
              state    <= EVAL;
              in_ready <= 1'b0;
            end
          end
        end
        EVAL: begin
          // Hand has been stable on the SMJ inputs for a full cycle.
          out_data  <= smj_data;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            hand_cnt  <= '0;
            state     <= COLLECT;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= COLLECT;
          hand_cnt <= '0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign hand_n0   = hand[0];
  assign hand_n1   = hand[1];
  assign hand_n2   = hand[2];
  assign hand_n3   = hand[3];
  assign hand_n4   = hand[4];
  assign state_dbg = state;

endmodule

// File: tb/tb_smj_hand_loader.sv
// Directed bench for smj_hand_loader: a vector table for the basic five-tile
// load and verdict release, plus hand-written sequences for back-pressure,
// flush and gapped input. Expected slot order follows HAND_SORT_EN.
import smj_pkg::*;

module tb_smj_hand_loader;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic [TILE_W-1:0] in_tile;
  logic              in_ready;
  logic [TILE_W-1:0] hand_n0, hand_n1, hand_n2, hand_n3, hand_n4;
  logic [RES_W-1:0]  smj_data;
  logic              out_valid;
  logic [RES_W-1:0]  out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  hand_cnt;
  logic [1:0]        state_dbg;

  int n_vec = 0;
  int n_err = 0;

  smj_hand_loader dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_tile   (in_tile),
    .in_ready  (in_ready),
    .hand_n0   (hand_n0),
    .hand_n1   (hand_n1),
    .hand_n2   (hand_n2),
    .hand_n3   (hand_n3),
    .hand_n4   (hand_n4),
    .smj_data  (smj_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .hand_cnt  (hand_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver / check tasks ----------------
  // One clock; outputs are sampled 1 ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_slots(input string tag, input int e0, input int e1, input int e2,
                           input int e3, input int e4);
    chk({tag, " slot0"}, 32'(hand_n0), 32'(e0));
    chk({tag, " slot1"}, 32'(hand_n1), 32'(e1));
    chk({tag, " slot2"}, 32'(hand_n2), 32'(e2));
    chk({tag, " slot3"}, 32'(hand_n3), 32'(e3));
    chk({tag, " slot4"}, 32'(hand_n4), 32'(e4));
  endtask

  task automatic load_tile(input int t);
    in_valid = 1'b1;
    in_tile  = TILE_W'(t);
    step();
    in_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              iv;
    logic [TILE_W-1:0] tile;
    logic              ordy;
    logic              exp_ir;
    logic              exp_ov;
    logic [RES_W-1:0]  exp_od;
    logic [CNT_W-1:0]  exp_cnt;
    logic [1:0]        exp_st;
  } vec_t;

  vec_t tbl[7];

  int verdicts;
  logic prev_ov;

  initial begin
    // Arrival-order load with out_ready already high; SMJ stub returns 2'b10.
    tbl[0] = '{1'b1, 6'd9,  1'b1, 1'b1, 1'b0, 2'd0, 3'd1, 2'd0};
    tbl[1] = '{1'b1, 6'd3,  1'b1, 1'b1, 1'b0, 2'd0, 3'd2, 2'd0};
    tbl[2] = '{1'b1, 6'd9,  1'b1, 1'b1, 1'b0, 2'd0, 3'd3, 2'd0};
    tbl[3] = '{1'b1, 6'd20, 1'b1, 1'b1, 1'b0, 2'd0, 3'd4, 2'd0};
    tbl[4] = '{1'b1, 6'd1,  1'b1, 1'b0, 1'b0, 2'd0, 3'd5, 2'd1};
    // EVAL cycle: in_valid with a tile that must be ignored.
    tbl[5] = '{1'b1, 6'd55, 1'b1, 1'b0, 1'b1, 2'd2, 3'd5, 2'd2};
    // HOLD with out_ready high: release and return to COLLECT.
    tbl[6] = '{1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 2'd2, 3'd0, 2'd0};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_tile   = 6'd33;
    out_ready = 1'b0;
    smj_data  = 2'b00;

    // ---- reset held 2 cycles with in_valid high ----
    step();
    step();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data",  32'(out_data),  0);
    chk("rst hand_cnt",  32'(hand_cnt),  0);
    chk("rst in_ready",  32'(in_ready),  1);
    chk("rst state",     32'(state_dbg), 32'(COLLECT));
    chk_slots("rst", 0, 0, 0, 0, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    chk("post-rst hand_cnt", 32'(hand_cnt), 0);

    // ---- table-driven arrival-order load ----
    smj_data = 2'b10;
    for (int i = 0; i < 7; i++) begin
      in_valid  = tbl[i].iv;
      in_tile   = tbl[i].tile;
      out_ready = tbl[i].ordy;
      step();
      chk($sformatf("tbl%0d in_ready", i),  32'(in_ready),  32'(tbl[i].exp_ir));
      chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d out_data", i),  32'(out_data),  32'(tbl[i].exp_od));
      chk($sformatf("tbl%0d hand_cnt", i),  32'(hand_cnt),  32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d state", i),     32'(state_dbg), 32'(tbl[i].exp_st));
    end
    in_valid = 1'b0;
`ifdef HAND_SORT_EN
    chk_slots("load", 1, 3, 9, 9, 20);
`else
    chk_slots("load", 9, 3, 9, 20, 1);
`endif

    // ---- back-pressure: verdict held for 10 cycles ----
    out_ready = 1'b0;
    smj_data  = 2'b01;
    load_tile(30);
    load_tile(25);
    load_tile(40);
    load_tile(25);
    load_tile(12);
    chk("bp eval out_valid", 32'(out_valid), 0);
    step();
    chk("bp rise out_valid", 32'(out_valid), 1);
    chk("bp rise out_data",  32'(out_data),  1);
    smj_data = 2'b11;  // later SMJ changes must not reach out_data
    in_valid = 1'b1;
    in_tile  = 6'd7;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp%0d in_ready", i),  32'(in_ready),  0);
      chk($sformatf("bp%0d out_valid", i), 32'(out_valid), 1);
      chk($sformatf("bp%0d out_data", i),  32'(out_data),  1);
      chk($sformatf("bp%0d hand_cnt", i),  32'(hand_cnt),  5);
    end
`ifdef HAND_SORT_EN
    chk_slots("bp", 12, 25, 25, 30, 40);
`else
    chk_slots("bp", 30, 25, 40, 25, 12);
`endif
    out_ready = 1'b1;
    step();
    chk("bp release out_valid", 32'(out_valid), 0);
    chk("bp release hand_cnt",  32'(hand_cnt),  0);
    chk("bp release in_ready",  32'(in_ready),  1);
    chk("bp release slot0",     32'(hand_n0),   32'(TILE_W'(30 - 18 * 0)) - 32'd0
`ifdef HAND_SORT_EN
        - 32'd18
`endif
        );
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("bp tile7 hand_cnt", 32'(hand_cnt), 1);
    chk("bp tile7 slot0",    32'(hand_n0),  7);

    // ---- flush mid-hand with a simultaneous tile ----
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush0 hand_cnt", 32'(hand_cnt), 0);
    load_tile(11);
    load_tile(12);
    load_tile(13);
    chk("pre-flush hand_cnt", 32'(hand_cnt), 3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_tile  = 6'd5;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush hand_cnt",  32'(hand_cnt),  0);
    chk("flush in_ready",  32'(in_ready),  1);
    chk("flush out_valid", 32'(out_valid), 0);
`ifdef HAND_SORT_EN
    chk_slots("flush", 11, 12, 13, 30, 40);
`else
    chk_slots("flush", 11, 12, 13, 25, 12);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush idle%0d out_valid", i), 32'(out_valid), 0);
    end

    // ---- flush during HOLD together with out_ready ----
    smj_data = 2'b11;
    load_tile(1);
    load_tile(2);
    load_tile(3);
    load_tile(4);
    load_tile(5);
    step();
    chk("hold out_valid", 32'(out_valid), 1);
    chk("hold out_data",  32'(out_data),  3);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("hflush out_valid", 32'(out_valid), 0);
    chk("hflush hand_cnt",  32'(hand_cnt),  0);
    chk("hflush state",     32'(state_dbg), 32'(COLLECT));
    chk("hflush in_ready",  32'(in_ready),  1);
    chk("hflush out_data",  32'(out_data),  3);

    // ---- gapped input: one tile every other cycle ----
    smj_data = 2'b01;
    verdicts = 0;
    prev_ov  = out_valid;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_tile  = TILE_W'(40 + i);
      step();
      chk($sformatf("gap%0d hand_cnt", i), 32'(hand_cnt), 32'((i / 2 + 1 > 5) ? 5 : i / 2 + 1));
      if (out_valid && !prev_ov) verdicts++;
      prev_ov = out_valid;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid && !prev_ov) verdicts++;
      prev_ov = out_valid;
    end
    chk("gap verdicts",  32'(verdicts),  1);
    chk("gap out_data",  32'(out_data),  1);
    chk("gap out_valid", 32'(out_valid), 0);
    chk_slots("gap", 40, 42, 44, 46, 48);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
